// File: rtl/scoring_pkg.sv
// Shared constants and user-ID table for the high-score tracker.
// Holds the command codes, ROM geometry and the fixed UID contents.
package scoring_pkg;

  localparam logic [2:0] CMD_SUBMIT  = 3'd3;
  localparam logic [2:0] CMD_DISPLAY = 3'd4;

  localparam int ROM_DEPTH = 32;
  localparam int ROM_WIDTH = 16;
  localparam int ROM_AW    = $clog2(ROM_DEPTH);

  function automatic logic [ROM_WIDTH-1:0] uid_lookup(
    input logic [ROM_AW-1:0] addr
  );
    logic [ROM_WIDTH-1:0] v;
    case (addr)
      5'd1:    v = 16'h1234;
      5'd2:    v = 16'h5678;
      5'd3:    v = 16'h9ABC;
      5'd4:    v = 16'hDEF0;
      5'd5:    v = 16'h1357;
      5'd6:    v = 16'h2468;
      5'd7:    v = 16'hACE1;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/scoring_uid_rom.sv
// UID_ROM: synchronous-read user-ID table, one cycle of latency.
// Ports: clk, address (5b) in; data (16b) out. No reset; powers up 0.
module UID_ROM
  import scoring_pkg::*;
(
  input  logic                clk,
  input  logic [ROM_AW-1:0]   address,
  output logic [ROM_WIDTH-1:0] data
);

  logic [ROM_WIDTH-1:0] q = '0;

  always_ff @(posedge clk) begin
    q <= uid_lookup(address);
  end

  assign data = q;

endmodule

// File: rtl/scoring.sv
// scoring: keeps the best valid non-guest BCD score and its holder, and
// drives UID_ROM (intIDout -> address, data -> topID) to show the holder.
// Ports: clk, rst (async, low); controlSig, isGuest, intIDin, scoreOnes,
// scoreTens, topID in; intIDout, topIDOne..Four, scoreOnesOut,
// scoreTensOut out.
module scoring
  import scoring_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  controlSig,
  input  logic        isGuest,
  input  logic [2:0]  intIDin,
  input  logic [3:0]  scoreOnes,
  input  logic [3:0]  scoreTens,
  input  logic [15:0] topID,
  output logic [4:0]  intIDout,
  output logic [3:0]  topIDOne,
  output logic [3:0]  topIDTwo,
  output logic [3:0]  topIDThree,
  output logic [3:0]  topIDFour,
  output logic [3:0]  scoreOnesOut,
  output logic [3:0]  scoreTensOut
);

  logic [3:0]  bestTens;
  logic [3:0]  bestOnes;
  logic [2:0]  bestID;
  logic [15:0] digits;

  logic is_submit;
  logic is_display;
  logic bcd_ok;
  logic better;
  logic take;

  assign is_submit  = (controlSig == CMD_SUBMIT);
  assign is_display = (controlSig == CMD_DISPLAY);

  // Valid BCD makes an 8-bit nibble compare equal to decimal order.
  assign bcd_ok = (scoreTens <= 4'd9) && (scoreOnes <= 4'd9);
  assign better = {scoreTens, scoreOnes} > {bestTens, bestOnes};
  assign take   = is_submit && !isGuest && bcd_ok && better;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bestTens <= '0;
      bestOnes <= '0;
      bestID   <= '0;
    end else if (take) begin
      bestTens <= scoreTens;
      bestOnes <= scoreOnes;
      bestID   <= intIDin;
    end
  end

  // Address and digits both load every display cycle; the ROM sits
  // between them, so digits settle two edges after the address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intIDout <= '0;
      digits   <= '0;
    end else if (is_display) begin
      intIDout <= {2'b00, bestID};
      digits   <= topID;
    end
  end

  assign topIDOne     = digits[15:12];
  assign topIDTwo     = digits[11:8];
  assign topIDThree   = digits[7:4];
  assign topIDFour    = digits[3:0];
  assign scoreOnesOut = bestOnes;
  assign scoreTensOut = bestTens;

endmodule

// File: tb/tb_scoring.sv
// Bench for scoring + UID_ROM: decimal-level model checked every cycle,
// plus literal expectations at key points of the directed sequence.
module tb_scoring;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  controlSig;
  logic        isGuest;
  logic [2:0]  intIDin;
  logic [3:0]  scoreOnes;
  logic [3:0]  scoreTens;
  logic [15:0] topID;
  logic [4:0]  intIDout;
  logic [3:0]  topIDOne;
  logic [3:0]  topIDTwo;
  logic [3:0]  topIDThree;
  logic [3:0]  topIDFour;
  logic [3:0]  scoreOnesOut;
  logic [3:0]  scoreTensOut;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  scoring dut (
    .clk          (clk),
    .rst          (rst),
    .controlSig   (controlSig),
    .isGuest      (isGuest),
    .intIDin      (intIDin),
    .scoreOnes    (scoreOnes),
    .scoreTens    (scoreTens),
    .topID        (topID),
    .intIDout     (intIDout),
    .topIDOne     (topIDOne),
    .topIDTwo     (topIDTwo),
    .topIDThree   (topIDThree),
    .topIDFour    (topIDFour),
    .scoreOnesOut (scoreOnesOut),
    .scoreTensOut (scoreTensOut)
  );

  UID_ROM rom (
    .clk     (clk),
    .address (intIDout),
    .data    (topID)
  );

  // Model: best score as a decimal number, holder, shown address and the
  // 16-bit user ID currently displayed.
  int          m_best = 0;
  int          m_id   = 0;
  int          m_addr = 0;
  logic [15:0] m_rom  = 16'h0;
  logic [15:0] m_show = 16'h0;
  logic [15:0] uid_tbl [0:31];

  initial begin
    for (int i = 0; i < 32; i++) uid_tbl[i] = 16'h0;
    uid_tbl[1] = 16'h1234;
    uid_tbl[2] = 16'h5678;
    uid_tbl[3] = 16'h9ABC;
    uid_tbl[4] = 16'hDEF0;
    uid_tbl[5] = 16'h1357;
    uid_tbl[6] = 16'h2468;
    uid_tbl[7] = 16'hACE1;
  end

  always @(negedge rst) begin
    m_best = 0;
    m_id   = 0;
    m_addr = 0;
    m_show = 16'h0;
  end

  always @(posedge clk) begin
    logic [15:0] rom_next;
    int t, o;
    rom_next = uid_tbl[m_addr];
    if (!rst) begin
      m_best = 0;
      m_id   = 0;
      m_addr = 0;
      m_show = 16'h0;
    end else if (controlSig == 3'd3) begin
      t = int'(scoreTens);
      o = int'(scoreOnes);
      if (!isGuest && t <= 9 && o <= 9 && t * 10 + o > m_best) begin
        m_best = t * 10 + o;
        m_id   = int'(intIDin);
      end
    end else if (controlSig == 3'd4) begin
      m_show = m_rom;
      m_addr = m_id;
    end
    m_rom = rom_next;
  end

  always @(negedge clk) begin
    logic [28:0] act, exp_v;
    act = {intIDout, topIDOne, topIDTwo, topIDThree, topIDFour,
           scoreTensOut, scoreOnesOut};
    exp_v = {5'(m_addr), m_show, 4'(m_best / 10), 4'(m_best % 10)};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL cycle_model t=%0t got %h want %h", $time, act, exp_v);
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #5;
    end
  endtask

  task automatic submit(input logic g, input logic [2:0] id,
                        input logic [3:0] t, input logic [3:0] o,
                        input int n);
    controlSig = 3'd3;
    isGuest    = g;
    intIDin    = id;
    scoreTens  = t;
    scoreOnes  = o;
    step(n);
    controlSig = 3'd0;
    isGuest    = 1'b0;
  endtask

  function automatic logic [31:0] shown();
    return {11'b0, intIDout, topIDOne, topIDTwo, topIDThree, topIDFour};
  endfunction

  function automatic logic [31:0] score();
    return {24'b0, scoreTensOut, scoreOnesOut};
  endfunction

  initial begin
    rst        = 1'b0;
    controlSig = 3'd0;
    isGuest    = 1'b0;
    intIDin    = 3'd0;
    scoreOnes  = 4'd0;
    scoreTens  = 4'd0;
    step(2);
    rst = 1'b1;
    step(1);
    check("reset_score", score(), 32'h00);
    check("reset_show", shown(), 32'h0_0000);

    controlSig = 3'd4;
    step(4);
    controlSig = 3'd0;
    check("empty_display", shown(), 32'h0_0000);

    submit(1'b0, 3'd1, 4'd0, 4'd4, 5);
    check("id1_score04", score(), 32'h04);
    controlSig = 3'd4;
    step(2);
    check("id1_addr_e1", {27'b0, intIDout}, 32'd1);
    step(1);
    check("id1_digits_e2", shown(), {11'b0, 5'd1, 16'h1234});
    step(9);
    controlSig = 3'd0;
    check("id1_digits_held", shown(), {11'b0, 5'd1, 16'h1234});

    submit(1'b0, 3'd2, 4'd1, 4'd4, 3);
    check("id2_score14", score(), 32'h14);
    controlSig = 3'd4;
    step(3);
    controlSig = 3'd0;
    check("id2_digits", shown(), {11'b0, 5'd2, 16'h5678});

    submit(1'b0, 3'd3, 4'd0, 4'd9, 2);
    check("lower_09", score(), 32'h14);
    submit(1'b0, 3'd4, 4'd1, 4'd4, 2);
    check("tie_14", score(), 32'h14);
    submit(1'b1, 3'd5, 4'd9, 4'd9, 2);
    check("guest_99", score(), 32'h14);
    submit(1'b0, 3'd6, 4'hA, 4'd0, 2);
    check("bad_tens", score(), 32'h14);
    submit(1'b0, 3'd6, 4'd1, 4'hF, 2);
    check("bad_ones", score(), 32'h14);
    controlSig = 3'd4;
    step(3);
    controlSig = 3'd0;
    check("holder_still_2", shown(), {11'b0, 5'd2, 16'h5678});

    // Submit immediately followed by display.
    controlSig = 3'd3;
    intIDin    = 3'd7;
    scoreTens  = 4'd5;
    scoreOnes  = 4'd0;
    step(1);
    controlSig = 3'd4;
    step(1);
    check("b2b_score50", score(), 32'h50);
    step(2);
    check("b2b_digits", shown(), {11'b0, 5'd7, 16'hACE1});
    step(1);

    // Reset one cycle after digits are valid, checked before the next edge.
    rst        = 1'b0;
    controlSig = 3'd0;
    #1;
    check("async_rst_score", score(), 32'h00);
    check("async_rst_show", shown(), 32'h0_0000);
    step(2);
    rst = 1'b1;
    step(1);
    controlSig = 3'd4;
    step(4);
    controlSig = 3'd0;
    check("post_rst_display", shown(), 32'h0_0000);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
